// File: rtl/trace_ctrl_pkg.sv
// Shared types and helpers for the trace buffer sequencing controller.
// No logic of its own.
// Not applicable (no handshakes).
package trace_ctrl_pkg;

  // Controller states; explicit encoding keeps waveforms readable across builds.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    POST      = 3'd2,
    DUMP_ADDR = 3'd3,
    DUMP_DATA = 3'd4
  } tc_state_e;

  // Post-trigger write count, limited to the buffer depth: capturing more than
  // one buffer's worth after the trigger would overwrite the trigger point itself.
  function automatic int unsigned tc_clamp(input int unsigned post_trig,
                                           input int unsigned tb_size);
    return (post_trig > tb_size) ? tb_size : post_trig;
  endfunction

endpackage

// File: rtl/trace_buffer_ctrl.sv
// Arms/stops trace capture around a trigger and dumps the captured window oldest-first.
// First beat RAM_LATENCY+1 cycles after dump_req; one beat per RAM_LATENCY+1 cycles.
// rd_valid is held with a stable address until rd_ready; no rd_ready->rd_valid path.
module trace_buffer_ctrl
  import trace_ctrl_pkg::*;
#(
  parameter int unsigned TB_SIZE     = 64,
  parameter int unsigned RAM_LATENCY = 1,
  localparam int AW = $clog2(TB_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          trigger,
  input  logic [AW:0]   post_trig,
  input  logic          dump_req,
  input  logic          valid_in,
  input  logic          inc_tb_ptr,
  output logic          tracing,
  output logic [AW-1:0] tb_read_address,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  output logic [AW:0]   fill,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0]   FULL     = (AW+1)'(TB_SIZE);
  localparam logic [AW:0]   ONE      = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [1:0]    LAT_LAST = 2'(RAM_LATENCY - 1);

  tc_state_e     state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] start;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] rd_idx_next;
  logic [AW:0]   cnt;
  logic [AW:0]   trig_cnt;
  logic [1:0]    lat;
  logic          done_q;
  logic          wr;
  logic          hs;
  logic          last_beat;

  // Everything visible to the buffer and host is decoded from registered state.
  assign tracing     = (state == ARMED) || (state == POST);
  assign rd_valid    = (state == DUMP_DATA);
  assign busy        = (state != IDLE);
  assign done        = done_q;
  assign wr          = tracing & valid_in & inc_tb_ptr;
  assign hs          = rd_valid & rd_ready;
  assign last_beat   = ({1'b0, rd_idx} == (fill - ONE));
  assign rd_last     = rd_valid & last_beat;
  assign rd_idx_next = rd_idx + PTR_ONE;
  // fill == TB_SIZE wraps to 0 in AW bits, giving oldest == wr_ptr as required.
  assign oldest      = wr_ptr - fill[AW-1:0];
  assign trig_cnt    = (AW+1)'(tc_clamp(32'(post_trig), TB_SIZE));

  // Mirror of the buffer's write pointer and the count of entries captured since arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      // arm is only honoured in IDLE (where no write can occur) and loses to dump_req.
      if (state == IDLE && arm && !dump_req) fill <= '0;
      else if (wr && fill != FULL)           fill <= fill + ONE;
    end
  end

  // Capture/dump sequencing, read-address generation and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      rd_idx          <= '0;
      lat             <= '0;
      start           <= '0;
      tb_read_address <= '0;
      done_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_req) begin
            state           <= DUMP_ADDR;
            rd_idx          <= '0;
            lat             <= '0;
            start           <= oldest;
            tb_read_address <= oldest;
            // An empty window completes immediately: done shows in the DUMP_ADDR cycle.
            done_q          <= (fill == '0);
          end else if (arm) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          // A write on the trigger cycle is pre-trigger history, so it is not counted here.
          if (trigger) begin
            cnt   <= trig_cnt;
            state <= (trig_cnt == '0) ? IDLE : POST;
          end
        end
        POST: begin
          if (wr) begin
            cnt <= cnt - ONE;
            if (cnt == ONE) state <= IDLE;
          end
        end
        DUMP_ADDR: begin
          if (fill == '0)            state <= IDLE;
          else if (lat == LAT_LAST)  state <= DUMP_DATA;
          else                       lat   <= lat + 2'd1;
        end
        DUMP_DATA: begin
          if (hs) begin
            if (last_beat) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              rd_idx          <= rd_idx_next;
              tb_read_address <= start + rd_idx_next;
              lat             <= '0;
              state           <= DUMP_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_buffer_ctrl.sv
// Bench for trace_buffer_ctrl (TB_SIZE=8, RAM_LATENCY=2): table-driven captures and dumps,
// hand sequences for empty dump, arm+dump collision and mid-dump reset, then random sessions
// checked against a transaction-level model of pointer, fill and expected readout order.
module tb_trace_buffer_ctrl;

  localparam int TS = 8;
  localparam int RL = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          trigger = 1'b0;
  logic [AW:0]   post_trig = '0;
  logic          dump_req = 1'b0;
  logic          valid_in = 1'b0;
  logic          inc_tb_ptr = 1'b0;
  logic          rd_ready = 1'b0;
  logic          tracing;
  logic [AW-1:0] tb_read_address;
  logic          rd_valid;
  logic          rd_last;
  logic [AW:0]   fill;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int m_wr_ptr = 0;   // model: buffer write pointer
  int m_fill = 0;     // model: entries captured since arm

  typedef struct packed {
    bit rst;
    int npre;
    int pt;
    bit wot;
    int exp_fill;
    int exp_start;
    int stall_beat;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  trace_buffer_ctrl #(.TB_SIZE(TS), .RAM_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trigger(trigger), .post_trig(post_trig),
    .dump_req(dump_req), .valid_in(valid_in), .inc_tb_ptr(inc_tb_ptr),
    .tracing(tracing), .tb_read_address(tb_read_address), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_last(rd_last), .fill(fill), .busy(busy), .done(done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampf(input int p);
    return (p > TS) ? TS : p;
  endfunction

  task automatic m_write();
    m_wr_ptr = (m_wr_ptr + 1) % TS;
    if (m_fill < TS) m_fill++;
  endtask

  task automatic check_idle_outputs(input string tag, input bit addr_zero);
    check({tag, "_tracing"}, int'(tracing), 0);
    check({tag, "_rd_valid"}, int'(rd_valid), 0);
    check({tag, "_rd_last"}, int'(rd_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    if (addr_zero) begin
      check({tag, "_fill"}, int'(fill), 0);
      check({tag, "_addr"}, int'(tb_read_address), 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 0; trigger = 0; dump_req = 0; valid_in = 0; inc_tb_ptr = 0;
    rd_ready = 0; post_trig = '0;
    repeat (2) tick();
    check_idle_outputs("reset", 1'b1);
    rst_n = 1'b1;
    tick();
    m_wr_ptr = 0;
    m_fill = 0;
  endtask

  // One capture: arm, npre pre-trigger cycles, trigger, then writes until capture ends.
  task automatic capture(input int npre, input int pt, input bit wot, input bit rnd);
    int rem;
    int guard;
    bit v;
    bit i;
    arm = 1; tick(); arm = 0;
    m_fill = 0;
    check("tracing_after_arm", int'(tracing), 1);
    check("fill_after_arm", int'(fill), 0);
    for (int k = 0; k < npre; k++) begin
      check("tracing_pre", int'(tracing), 1);
      v = rnd ? bit'($urandom_range(0, 3) != 0) : 1'b1;
      i = rnd ? bit'($urandom_range(0, 3) != 0) : 1'b1;
      valid_in = v; inc_tb_ptr = i;
      dump_req = rnd ? bit'($urandom_range(0, 7) == 0) : 1'b0;
      if (v && i) m_write();
      tick();
    end
    dump_req = 0;
    trigger = 1; post_trig = (AW+1)'(pt); valid_in = wot; inc_tb_ptr = wot;
    if (wot) m_write();
    tick();
    trigger = 0; valid_in = 0; inc_tb_ptr = 0;
    rem = clampf(pt);
    guard = 0;
    while (rem > 0) begin
      check("tracing_post", int'(tracing), 1);
      v = (rnd && guard < 30) ? bit'($urandom_range(0, 3) != 0) : 1'b1;
      i = (rnd && guard < 30) ? bit'($urandom_range(0, 3) != 0) : 1'b1;
      valid_in = v; inc_tb_ptr = i;
      arm = rnd ? bit'($urandom_range(0, 5) == 0) : 1'b0;
      trigger = rnd ? bit'($urandom_range(0, 5) == 0) : 1'b0;
      dump_req = rnd ? bit'($urandom_range(0, 5) == 0) : 1'b0;
      if (v && i) begin
        m_write();
        rem--;
      end
      tick();
      guard++;
    end
    arm = 0; trigger = 0; dump_req = 0; valid_in = 0; inc_tb_ptr = 0;
    check("tracing_end", int'(tracing), 0);
    valid_in = 1; inc_tb_ptr = 1;
    repeat (2) tick();
    valid_in = 0; inc_tb_ptr = 0;
    check("fill_end", int'(fill), m_fill);
    check("busy_end", int'(busy), 0);
  endtask

  // Deterministic dump with an optional stall and optional simultaneous arm.
  task automatic do_dump(input int ef, input int es, input int stall_beat,
                         input int stall_len, input bit with_arm);
    int waited;
    int held;
    dump_req = 1; arm = with_arm; rd_ready = 1;
    tick();
    dump_req = 0; arm = 0;
    if (ef == 0) begin
      check("empty_done", int'(done), 1);
      check("empty_rd_valid", int'(rd_valid), 0);
      tick();
      check("empty_done_drop", int'(done), 0);
      check("empty_busy", int'(busy), 0);
      check("empty_tracing", int'(tracing), 0);
      return;
    end
    for (int b = 0; b < ef; b++) begin
      waited = 0;
      while (!rd_valid && waited < 10) begin
        tick();
        waited++;
      end
      check($sformatf("beat%0d_gap", b), waited, RL);
      check($sformatf("beat%0d_addr", b), int'(tb_read_address), (es + b) % TS);
      check($sformatf("beat%0d_last", b), int'(rd_last), int'(b == ef - 1));
      check("dump_tracing", int'(tracing), 0);
      if (b == stall_beat) begin
        held = int'(tb_read_address);
        rd_ready = 0;
        repeat (stall_len) begin
          tick();
          check("stall_valid", int'(rd_valid), 1);
          check("stall_addr", int'(tb_read_address), held);
        end
        rd_ready = 1;
      end
      tick();
    end
    check("dump_done", int'(done), 1);
    check("dump_valid_drop", int'(rd_valid), 0);
    tick();
    check("dump_done_drop", int'(done), 0);
    check("dump_busy", int'(busy), 0);
    check("dump_fill_kept", int'(fill), ef);
    check("dump_tracing_after", int'(tracing), 0);
    rd_ready = 0;
  endtask

  // Dump with random rd_ready, scored against the model's oldest-first address list.
  task automatic rdump();
    int exp_q[$];
    int got;
    int cyc;
    int held_addr;
    bit holding;
    bit expect_done;
    for (int k = 0; k < m_fill; k++) exp_q.push_back((m_wr_ptr - m_fill + k + 2 * TS) % TS);
    dump_req = 1; rd_ready = 0;
    tick();
    dump_req = 0;
    got = 0; cyc = 0; holding = 0; held_addr = 0;
    expect_done = (m_fill == 0);
    while (!done && cyc < 300) begin
      if (holding) begin
        check("rnd_hold_valid", int'(rd_valid), 1);
        check("rnd_hold_addr", int'(tb_read_address), held_addr);
      end
      rd_ready = bit'($urandom_range(0, 1));
      if (rd_valid) begin
        if (rd_ready) begin
          got++;
          if (exp_q.size() == 0) begin
            check("rnd_beat_count", got, m_fill);
          end else begin
            check("rnd_addr", int'(tb_read_address), exp_q.pop_front());
            check("rnd_last", int'(rd_last), int'(exp_q.size() == 0));
            expect_done = (exp_q.size() == 0);
          end
          holding = 0;
        end else begin
          holding = 1;
          held_addr = int'(tb_read_address);
        end
      end
      tick();
      cyc++;
      if (expect_done) check("rnd_done_timing", int'(done), 1);
    end
    check("rnd_done", int'(done), 1);
    check("rnd_beats", got, m_fill);
    rd_ready = 0;
    tick();
    check("rnd_done_pulse", int'(done), 0);
  endtask

  initial begin
    int beats;
    int guard;
    tbl[0] = '{1'b1,  5,  2, 1'b0, 7, 0,  2};
    tbl[1] = '{1'b1, 11,  1, 1'b0, 8, 4, -1};
    tbl[2] = '{1'b0,  2,  0, 1'b1, 3, 4, -1};
    tbl[3] = '{1'b0,  3, 12, 1'b1, 8, 3,  0};
    tbl[4] = '{1'b0,  0,  3, 1'b0, 3, 3, -1};

    // Empty dumps straight out of reset, alone and colliding with arm.
    do_reset();
    do_dump(0, 0, -1, 0, 1'b0);
    do_dump(0, 0, -1, 0, 1'b1);

    for (int t = 0; t < 5; t++) begin
      if (tbl[t].rst) do_reset();
      capture(tbl[t].npre, tbl[t].pt, tbl[t].wot, 1'b0);
      check($sformatf("tbl%0d_fill", t), int'(fill), tbl[t].exp_fill);
      do_dump(tbl[t].exp_fill, tbl[t].exp_start, tbl[t].stall_beat, 5, 1'b0);
    end

    // arm together with dump_req: dump runs, arm is dropped, fill is kept.
    do_dump(3, 3, -1, 0, 1'b1);

    for (int s = 0; s < 25; s++) begin
      capture($urandom_range(0, 20), $urandom_range(0, 15), bit'($urandom_range(0, 1)), 1'b1);
      rdump();
    end

    // Reset during beat 3 of a full-window dump.
    capture(6, 2, 1'b0, 1'b0);
    check("pre_reset_fill", int'(fill), m_fill);
    dump_req = 1; rd_ready = 1;
    tick();
    dump_req = 0;
    beats = 0; guard = 0;
    while (beats < 3 && guard < 100) begin
      if (rd_valid) beats++;
      tick();
      guard++;
    end
    guard = 0;
    while (!rd_valid && guard < 10) begin
      tick();
      guard++;
    end
    check("beat3_valid", int'(rd_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset", 1'b1);
    rd_ready = 0;
    tick();
    rst_n = 1'b1;
    tick();
    m_wr_ptr = 0;
    m_fill = 0;
    capture(2, 1, 1'b0, 1'b0);
    check("after_reset_fill", int'(fill), 3);
    rdump();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
